// File: rtl/darkbus_arbiter.sv
// Two-provider round-robin arbiter in front of a single darkbus consumer.
// The owner's strobes pass straight through, and an acknowledge timeout can abort a stalled transfer.
module darkbus_arbiter #(
    parameter int          TIMEOUT = 255,
    parameter logic [31:0] ERRDATA = 32'hFFFF_FFFF
) (
    input  logic        CLK,
    input  logic        RESn,
    input  logic        P0_EN,
    input  logic        P0_RE,
    input  logic        P0_WE,
    input  logic [3:0]  P0_BE,
    input  logic [31:0] P0_ADDR,
    input  logic [31:0] P0_WDATA,
    output logic [31:0] P0_RDATA,
    output logic        P0_RACK,
    output logic        P0_WACK,
    output logic        P0_ERR,
    input  logic        P1_EN,
    input  logic        P1_RE,
    input  logic        P1_WE,
    input  logic [3:0]  P1_BE,
    input  logic [31:0] P1_ADDR,
    input  logic [31:0] P1_WDATA,
    output logic [31:0] P1_RDATA,
    output logic        P1_RACK,
    output logic        P1_WACK,
    output logic        P1_ERR,
    output logic        C_EN,
    output logic        C_RE,
    output logic        C_WE,
    output logic [3:0]  C_BE,
    output logic [31:0] C_ADDR,
    output logic [31:0] C_WDATA,
    input  logic [31:0] C_RDATA,
    input  logic        C_RACK,
    input  logic        C_WACK,
    output logic [1:0]  GNT
);

    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] TOUT_VAL = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic             TOUT_ON  = (TIMEOUT != 32'sd0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_TOUT = 2'd2;

    logic [1:0]       state_r, state_nxt_s;
    logic [1:0]       owner_r, owner_nxt_s;
    logic             last_r, last_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;

    logic        req0_s, req1_s, ack_s, abort_s, tout_hit_s;
    logic        own_en_s, own_re_s, own_we_s;
    logic [3:0]  own_be_s;
    logic [31:0] own_addr_s, own_wdata_s;

    assign req0_s     = P0_EN & (P0_RE | P0_WE);
    assign req1_s     = P1_EN & (P1_RE | P1_WE);
    assign ack_s      = C_RACK | C_WACK;
    assign abort_s    = (state_r == ST_BUSY) & ~own_en_s;
    // The counter is compared after incrementing, so TIMEOUT counts whole BUSY cycles.
    assign cnt_inc_s  = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);
    assign tout_hit_s = TOUT_ON & (cnt_inc_s == TOUT_VAL);

    // Select the current owner's request signals.
    always_comb begin
        own_en_s    = 1'b0;
        own_re_s    = 1'b0;
        own_we_s    = 1'b0;
        own_be_s    = 4'h0;
        own_addr_s  = 32'h0;
        own_wdata_s = 32'h0;
        case (owner_r)
            2'b01: begin
                own_en_s    = P0_EN;
                own_re_s    = P0_RE;
                own_we_s    = P0_WE;
                own_be_s    = P0_BE;
                own_addr_s  = P0_ADDR;
                own_wdata_s = P0_WDATA;
            end
            2'b10: begin
                own_en_s    = P1_EN;
                own_re_s    = P1_RE;
                own_we_s    = P1_WE;
                own_be_s    = P1_BE;
                own_addr_s  = P1_ADDR;
                own_wdata_s = P1_WDATA;
            end
            default: begin
                own_en_s = 1'b0;
            end
        endcase
    end

    // Next-state logic: arbitration, completion, abort and timeout.
    always_comb begin
        state_nxt_s = state_r;
        owner_nxt_s = owner_r;
        last_nxt_s  = last_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = {CNT_W{1'b0}};
                if (req0_s & req1_s) begin
                    owner_nxt_s = last_r ? 2'b01 : 2'b10;
                    state_nxt_s = ST_BUSY;
                end else if (req0_s) begin
                    owner_nxt_s = 2'b01;
                    state_nxt_s = ST_BUSY;
                end else if (req1_s) begin
                    owner_nxt_s = 2'b10;
                    state_nxt_s = ST_BUSY;
                end else begin
                    owner_nxt_s = 2'b00;
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (abort_s | ack_s) begin
                    state_nxt_s = ST_IDLE;
                    last_nxt_s  = owner_r[1];
                    owner_nxt_s = 2'b00;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else if (tout_hit_s) begin
                    state_nxt_s = ST_TOUT;
                    cnt_nxt_s   = cnt_inc_s;
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                end
            end
            ST_TOUT: begin
                state_nxt_s = ST_IDLE;
                last_nxt_s  = owner_r[1];
                owner_nxt_s = 2'b00;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
            default: begin
                state_nxt_s = ST_IDLE;
                owner_nxt_s = 2'b00;
                last_nxt_s  = 1'b1;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State registers; LAST resets to P1 so P0 wins the first tie.
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            state_r <= ST_IDLE;
            owner_r <= 2'b00;
            last_r  <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            owner_r <= owner_nxt_s;
            last_r  <= last_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Output routing; everything idles at zero outside BUSY/TOUT.
    always_comb begin
        C_EN     = 1'b0;
        C_RE     = 1'b0;
        C_WE     = 1'b0;
        C_BE     = 4'h0;
        C_ADDR   = 32'h0;
        C_WDATA  = 32'h0;
        P0_RDATA = 32'h0;
        P0_RACK  = 1'b0;
        P0_WACK  = 1'b0;
        P0_ERR   = 1'b0;
        P1_RDATA = 32'h0;
        P1_RACK  = 1'b0;
        P1_WACK  = 1'b0;
        P1_ERR   = 1'b0;
        GNT      = 2'b00;
        case (state_r)
            ST_BUSY: begin
                GNT = owner_r;
                if (own_en_s) begin
                    C_EN    = 1'b1;
                    C_RE    = own_re_s;
                    C_WE    = own_we_s;
                    C_BE    = own_be_s;
                    C_ADDR  = own_addr_s;
                    C_WDATA = own_wdata_s;
                    if (owner_r == 2'b01) begin
                        P0_RACK  = C_RACK;
                        P0_WACK  = C_WACK;
                        P0_RDATA = C_RDATA;
                    end else if (owner_r == 2'b10) begin
                        P1_RACK  = C_RACK;
                        P1_WACK  = C_WACK;
                        P1_RDATA = C_RDATA;
                    end else begin
                        P0_RACK = 1'b0;
                    end
                end else begin
                    C_EN = 1'b0;
                end
            end
            ST_TOUT: begin
                GNT = owner_r;
                if (owner_r == 2'b01) begin
                    P0_ERR   = 1'b1;
                    P0_RACK  = P0_RE;
                    P0_WACK  = P0_WE;
                    P0_RDATA = ERRDATA;
                end else if (owner_r == 2'b10) begin
                    P1_ERR   = 1'b1;
                    P1_RACK  = P1_RE;
                    P1_WACK  = P1_WE;
                    P1_RDATA = ERRDATA;
                end else begin
                    P0_ERR = 1'b0;
                end
            end
            default: begin
                GNT = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_darkbus_arbiter.sv
// Directed bench for darkbus_arbiter: expected provider responses go into a scoreboard
// queue, and a negedge monitor pops each entry and compares it when an ack or error shows up.
module tb_darkbus_arbiter;

    logic        CLK = 1'b0;
    logic        RESn;
    logic        P0_EN, P0_RE, P0_WE, P1_EN, P1_RE, P1_WE;
    logic [3:0]  P0_BE, P1_BE;
    logic [31:0] P0_ADDR, P0_WDATA, P1_ADDR, P1_WDATA;
    logic [31:0] P0_RDATA, P1_RDATA;
    logic        P0_RACK, P0_WACK, P0_ERR, P1_RACK, P1_WACK, P1_ERR;
    logic        C_EN, C_RE, C_WE;
    logic [3:0]  C_BE;
    logic [31:0] C_ADDR, C_WDATA, C_RDATA;
    logic        C_RACK, C_WACK;
    logic [1:0]  GNT;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        port;
        logic        rack;
        logic        wack;
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb_q[$];

    darkbus_arbiter #(.TIMEOUT(4), .ERRDATA(32'hFFFF_FFFF)) dut (
        .CLK(CLK), .RESn(RESn),
        .P0_EN(P0_EN), .P0_RE(P0_RE), .P0_WE(P0_WE), .P0_BE(P0_BE),
        .P0_ADDR(P0_ADDR), .P0_WDATA(P0_WDATA), .P0_RDATA(P0_RDATA),
        .P0_RACK(P0_RACK), .P0_WACK(P0_WACK), .P0_ERR(P0_ERR),
        .P1_EN(P1_EN), .P1_RE(P1_RE), .P1_WE(P1_WE), .P1_BE(P1_BE),
        .P1_ADDR(P1_ADDR), .P1_WDATA(P1_WDATA), .P1_RDATA(P1_RDATA),
        .P1_RACK(P1_RACK), .P1_WACK(P1_WACK), .P1_ERR(P1_ERR),
        .C_EN(C_EN), .C_RE(C_RE), .C_WE(C_WE), .C_BE(C_BE),
        .C_ADDR(C_ADDR), .C_WDATA(C_WDATA), .C_RDATA(C_RDATA),
        .C_RACK(C_RACK), .C_WACK(C_WACK), .GNT(GNT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_rsp(input logic port, input logic rack, input logic wack,
                              input logic err, input logic [31:0] rdata);
        exp_t e;
        e.port = port; e.rack = rack; e.wack = wack; e.err = err; e.rdata = rdata;
        sb_q.push_back(e);
    endtask

    task automatic mon_cmp(input logic port, input logic rack, input logic wack,
                           input logic err, input logic [31:0] rdata);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected port=%0d got rack=%b wack=%b err=%b rdata=%h expected none at %0t",
                     port, rack, wack, err, rdata, $time);
        end else begin
            e = sb_q.pop_front();
            if (e.port !== port || e.rack !== rack || e.wack !== wack || e.err !== err || e.rdata !== rdata) begin
                errors++;
                $display("FAIL sb_rsp got port=%0d rack=%b wack=%b err=%b rdata=%h expected port=%0d rack=%b wack=%b err=%b rdata=%h at %0t",
                         port, rack, wack, err, rdata, e.port, e.rack, e.wack, e.err, e.rdata, $time);
            end
        end
    endtask

    // Monitor: every visible provider response must match the next scoreboard entry.
    always @(negedge CLK) begin
        if (RESn === 1'b1) begin
            if (P0_RACK | P0_WACK | P0_ERR) mon_cmp(1'b0, P0_RACK, P0_WACK, P0_ERR, P0_RDATA);
            if (P1_RACK | P1_WACK | P1_ERR) mon_cmp(1'b1, P1_RACK, P1_WACK, P1_ERR, P1_RDATA);
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, {30'd0, GNT}, 32'd0);
        chk({tag, "_cstrb"}, {25'd0, C_EN, C_RE, C_WE, C_BE}, 32'd0);
        chk({tag, "_caddr"}, C_ADDR, 32'd0);
        chk({tag, "_cwdata"}, C_WDATA, 32'd0);
        chk({tag, "_p0rdata"}, P0_RDATA, 32'd0);
        chk({tag, "_p1rdata"}, P1_RDATA, 32'd0);
        chk({tag, "_acks"}, {26'd0, P0_RACK, P0_WACK, P0_ERR, P1_RACK, P1_WACK, P1_ERR}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        RESn = 1'b0;
        {P0_EN, P0_RE, P0_WE, P1_EN, P1_RE, P1_WE} = 6'b0;
        P0_BE = 4'hF; P1_BE = 4'hF;
        P0_ADDR = 32'h10; P1_ADDR = 32'h20;
        P0_WDATA = 32'h0; P1_WDATA = 32'h0;
        C_RDATA = 32'h5A5A_5A5A; C_RACK = 1'b1; C_WACK = 1'b1;
        repeat (3) tick();
        chk_all_zero("reset");
        C_RDATA = 32'h0; C_RACK = 1'b0; C_WACK = 1'b0;

        // Both providers read from the first edge after reset: P0 first, then P1 after one dead cycle.
        {P0_EN, P0_RE, P1_EN, P1_RE} = 4'b1111;
        RESn = 1'b1;
        tick();
        chk("rr_first_gnt", {30'd0, GNT}, 32'd1);
        chk("rr_first_cen", {31'd0, C_EN}, 32'd1);
        chk("rr_first_caddr", C_ADDR, 32'h10);
        expect_rsp(1'b0, 1'b1, 1'b0, 1'b0, 32'hA5A5_0001);
        C_RACK = 1'b1; C_RDATA = 32'hA5A5_0001;
        #1 chk("rr_first_p1rack", {31'd0, P1_RACK}, 32'd0);
        tick();
        C_RACK = 1'b0; C_RDATA = 32'h0;
        {P0_EN, P0_RE} = 2'b00;
        chk("rr_dead_gnt", {30'd0, GNT}, 32'd0);
        chk("rr_dead_cen", {31'd0, C_EN}, 32'd0);
        tick();
        chk("rr_second_gnt", {30'd0, GNT}, 32'd2);
        chk("rr_second_caddr", C_ADDR, 32'h20);
        expect_rsp(1'b1, 1'b1, 1'b0, 1'b0, 32'hA5A5_0002);
        C_RACK = 1'b1; C_RDATA = 32'hA5A5_0002;
        tick();
        C_RACK = 1'b0; C_RDATA = 32'h0;
        {P1_EN, P1_RE} = 2'b00;
        tick();

        // P1 write acknowledged in its third BUSY cycle.
        P1_ADDR = 32'h100; P1_WDATA = 32'hDEAD_BEEF; P1_BE = 4'hF;
        {P1_EN, P1_WE} = 2'b11;
        tick();
        for (int c = 0; c < 3; c++) begin
            chk("wr_gnt", {30'd0, GNT}, 32'd2);
            chk("wr_cstrb", {25'd0, C_EN, C_RE, C_WE, C_BE}, {25'd0, 3'b101, 4'hF});
            chk("wr_caddr", C_ADDR, 32'h100);
            chk("wr_cwdata", C_WDATA, 32'hDEAD_BEEF);
            if (c == 2) begin
                expect_rsp(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
                C_WACK = 1'b1;
                #1 chk("wr_p0_noack", {30'd0, P0_RACK, P0_WACK}, 32'd0);
            end
            tick();
        end
        C_WACK = 1'b0;
        {P1_EN, P1_WE} = 2'b00;
        chk("wr_done_gnt", {30'd0, GNT}, 32'd0);
        tick();

        // P0 read with no consumer ack: four BUSY cycles, then one TOUT cycle.
        {P0_EN, P0_RE} = 2'b11;
        tick();
        for (int c = 0; c < 4; c++) begin
            chk("to_busy_gnt", {30'd0, GNT}, 32'd1);
            chk("to_busy_cen", {31'd0, C_EN}, 32'd1);
            chk("to_busy_err", {31'd0, P0_ERR}, 32'd0);
            if (c == 3) expect_rsp(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
            tick();
        end
        chk("to_tout_cen", {31'd0, C_EN}, 32'd0);
        chk("to_tout_gnt", {30'd0, GNT}, 32'd1);
        chk("to_tout_err", {30'd0, P0_ERR, P1_ERR}, 32'd2);
        tick();
        {P0_EN, P0_RE} = 2'b00;
        chk("to_idle_gnt", {30'd0, GNT}, 32'd0);
        tick();

        // Ack in the same cycle the counter reaches TIMEOUT completes normally.
        {P0_EN, P0_RE} = 2'b11;
        tick();
        for (int c = 0; c < 4; c++) begin
            chk("race_gnt", {30'd0, GNT}, 32'd1);
            if (c == 3) begin
                expect_rsp(1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_5678);
                C_RACK = 1'b1; C_RDATA = 32'h1234_5678;
            end
            tick();
        end
        C_RACK = 1'b0; C_RDATA = 32'h0;
        {P0_EN, P0_RE} = 2'b00;
        chk("race_idle_gnt", {30'd0, GNT}, 32'd0);
        chk("race_no_err", {31'd0, P0_ERR}, 32'd0);
        tick();

        // Owner drops EN mid-transaction: strobes forced low, no error, back to IDLE.
        {P0_EN, P0_RE} = 2'b11;
        tick();
        chk("abort_gnt", {30'd0, GNT}, 32'd1);
        P0_EN = 1'b0;
        #1 chk("abort_cstrb", {25'd0, C_EN, C_RE, C_WE, C_BE}, 32'd0);
        chk("abort_caddr", C_ADDR, 32'd0);
        tick();
        chk("abort_idle_gnt", {30'd0, GNT}, 32'd0);
        chk("abort_no_err", {31'd0, P0_ERR}, 32'd0);

        // After P0 aborted, P1 wins the tie; then reset is asserted mid-BUSY.
        P1_ADDR = 32'h20;
        {P0_EN, P0_RE, P1_EN, P1_RE} = 4'b1111;
        tick();
        chk("tie_after_abort_gnt", {30'd0, GNT}, 32'd2);
        chk("tie_after_abort_caddr", C_ADDR, 32'h20);
        #2 RESn = 1'b0;
        #1 chk_all_zero("async_rst");
        repeat (2) tick();

        // Continuous contention for ten transactions must alternate 0,1,0,1,...
        RESn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("alt_gnt", {30'd0, GNT}, i[0] ? 32'd2 : 32'd1);
            chk("alt_caddr", C_ADDR, i[0] ? 32'h20 : 32'h10);
            expect_rsp(i[0], 1'b1, 1'b0, 1'b0, 32'hC000_0000 + 32'(i));
            C_RACK = 1'b1; C_RDATA = 32'hC000_0000 + 32'(i);
            tick();
            C_RACK = 1'b0; C_RDATA = 32'h0;
            chk("alt_dead_gnt", {30'd0, GNT}, 32'd0);
        end
        {P0_EN, P0_RE, P1_EN, P1_RE} = 4'b0000;
        repeat (2) tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/darkbus_arbiter.md
DARKBUS_ARBITER -- requirements
Module: darkbus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, is the number of BUSY cycles without a consumer acknowledge before the arbiter aborts; 0 disables the timeout.
REQ-002 Parameter ERRDATA, default 32'hFFFFFFFF, is the read data returned to a provider on a timeout abort.
REQ-003 CLK  in  1  sole clock, rising edge.
REQ-004 RESn  in  1  reset, asynchronous, active-low.
REQ-005 Pn_EN  in  1  provider n request enable, n in {0,1}.
REQ-006 Pn_RE / Pn_WE  in  1 each  provider n read / write strobe.
REQ-007 Pn_BE  in  4  provider n byte enables.
REQ-008 Pn_ADDR  in  32  provider n address.
REQ-009 Pn_WDATA  in  32  provider n write data; the split in/out form replaces the inout DATA.
REQ-010 Pn_RDATA  out  32  read data to provider n.
REQ-011 Pn_RACK / Pn_WACK  out  1 each  read / write acknowledge to provider n.
REQ-012 Pn_ERR  out  1  one-cycle timeout pulse to provider n.
REQ-013 C_EN, C_RE, C_WE  out  1 each  consumer-side strobes.
REQ-014 C_BE  out  4  consumer-side byte enables.
REQ-015 C_ADDR  out  32  consumer-side address.
REQ-016 C_WDATA  out  32  consumer-side write data.
REQ-017 C_RDATA  in  32  consumer read data.
REQ-018 C_RACK / C_WACK  in  1 each  consumer acknowledges.
REQ-019 GNT  out  2  one-hot current owner; 2'b00 when no owner.

Function
REQ-020 A provider requests when Pn_EN & (Pn_RE | Pn_WE).
REQ-021 States: IDLE, BUSY, TOUT, encoded in a registered FSM.
REQ-022 IDLE, single requester: that provider becomes OWNER; next state BUSY.
REQ-023 IDLE, both requesting: the provider not equal to LAST becomes OWNER (round-robin); next state BUSY.
REQ-024 IDLE, no request: stay in IDLE; all C_* outputs are 0.
REQ-025 Latency: C_EN rises exactly 1 cycle after the cycle in which the request is first sampled in IDLE.
REQ-026 BUSY: C_EN/RE/WE/BE/ADDR/WDATA pass combinationally from the OWNER inputs.
REQ-027 BUSY: OWNER RACK/WACK/RDATA pass combinationally from C_RACK/C_WACK/C_RDATA.
REQ-028 Non-owner RACK, WACK and ERR are 0, and non-owner RDATA is 32'h0, at all times.
REQ-029 BUSY completion: C_RACK | C_WACK high -> LAST <= OWNER, counter cleared, next state IDLE.
REQ-030 Completion takes one clock: owner ack cycle -> IDLE -> new grant, so there is a minimum of 1 dead cycle between transactions.
REQ-031 BUSY abort: owner Pn_EN low before any ack -> C_* outputs forced to 0 that cycle, LAST <= OWNER, next state IDLE, with no ERR.
REQ-032 Simultaneous Pn_RE & Pn_WE is forwarded unchanged, and the first consumer ack of either kind completes the transaction.
REQ-033 Timeout counter: 8 bits minimum, wide enough for TIMEOUT; increments on each BUSY cycle without an ack; saturates, never wraps.
REQ-034 When TIMEOUT != 0 and the counter equals TIMEOUT with no ack that cycle: next state TOUT.
REQ-035 TOUT, one cycle: C_* outputs are 0 and the owner Pn_ERR is 1.
REQ-036 TOUT: owner Pn_RACK = Pn_RE, owner Pn_WACK = Pn_WE, and owner Pn_RDATA = ERRDATA.
REQ-037 TOUT: LAST <= OWNER, counter cleared, next state IDLE.
REQ-038 A consumer ack arriving in the same cycle the counter reaches TIMEOUT takes priority as a normal completion.
REQ-039 A consumer ack seen in IDLE or TOUT is ignored.
REQ-040 GNT equals the one-hot OWNER in BUSY and TOUT, and is 0 in IDLE.

Reset
REQ-041 RESn low asynchronously forces the following, including mid-transaction: state IDLE, OWNER none, LAST=1 (P0 wins first tie), counter 0.
REQ-042 Under reset all outputs are 0: C_*, Pn_RACK/WACK/ERR, Pn_RDATA, GNT.
REQ-043 After RESn rises, the first request is sampled on the first rising CLK edge.

Verification
REQ-044 Reset release, P0 and P1 both read at the same edge -> P0 granted (GNT=01), then P1 granted after P0 completes, with 1 dead cycle between.
REQ-045 P1 write, ADDR=32'h100, WDATA=32'hDEADBEEF, BE=4'hF, consumer WACK after 3 cycles -> C_* match P1 during BUSY, P1_WACK pulses once, P0 sees no ack.
REQ-046 TIMEOUT=4, P0 read, consumer never acks -> 4 BUSY cycles, then P0_ERR=1, P0_RACK=1, P0_RDATA=32'hFFFFFFFF for one cycle, then IDLE.
REQ-047 Ack in the same cycle the counter hits TIMEOUT -> normal completion, P0_ERR stays 0.
REQ-048 RESn asserted during BUSY -> all outputs 0 asynchronously, before the next CLK edge.
REQ-049 Both providers request continuously for 10 transactions -> grants alternate 0,1,0,1..., with no starvation.
